// File: rtl/conv_pkg.sv
// Shared definitions for the convolution line-buffer controller: FSM encoding
// and the pixel / coordinate widths.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int PIX_W   = 16;
    localparam int COORD_W = 10;

endpackage

// File: rtl/conv_linebuf_ctrl_if.sv
// Pixel-in / line-buffer / window-out signal bundle of the line-buffer controller.
// The slave side is the controller, the master side drives pixels and observes strobes.
interface conv_linebuf_ctrl_if;
    import conv_pkg::*;

    logic               in_vs;
    logic               in_de;
    logic [PIX_W-1:0]   in_data;
    logic               lb_wr_en;
    logic [PIX_W-1:0]   lb_wr_data;
    logic               lb_rd_en;
    logic               lb_rd_hs;
    logic               win_valid;
    logic [COORD_W-1:0] win_row;
    logic [COORD_W-1:0] win_col;
    logic               win_border;
    logic               frame_done;
    logic               err_line;

    modport master (
        output in_vs, in_de, in_data,
        input  lb_wr_en, lb_wr_data, lb_rd_en, lb_rd_hs,
        input  win_valid, win_row, win_col, win_border, frame_done, err_line
    );

    modport slave (
        input  in_vs, in_de, in_data,
        output lb_wr_en, lb_wr_data, lb_rd_en, lb_rd_hs,
        output win_valid, win_row, win_col, win_border, frame_done, err_line
    );

endinterface

// File: rtl/conv_delay_line.sv
// 1-bit shift register of depth DEPTH with synchronous clear; q_pre is the tap one
// stage ahead of q so the consumer can see the end of a run of ones one cycle early.
module conv_delay_line #(
    parameter int DEPTH = 3
) (
    input  logic pclk,
    input  logic rst,
    input  logic clr,
    input  logic d,
    output logic q,
    output logic q_pre
);

    logic [DEPTH-1:0] stage_reg;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            stage_reg <= '0;
        end else if (clr) begin
            stage_reg <= '0;
        end else begin
            stage_reg[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign q = stage_reg[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_pre_in
            assign q_pre = d;
        end else begin : g_pre_tap
            assign q_pre = stage_reg[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/conv_linebuf_ctrl.sv
// Sequencer for a 3-row convolution line buffer: turns vs/de timing into write,
// read and row-toggle strobes, and emits aligned 3x3 window coordinates.
module conv_linebuf_ctrl
    import conv_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int RD_LAT   = 3
) (
    input  logic               pclk,
    input  logic               rst,
    conv_linebuf_ctrl_if.slave bus
);

    localparam int DRAIN_W = $clog2(RD_LAT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(RD_LAT - 1);
    localparam logic [COORD_W-1:0] COL_LEN   = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] COL_LAST  = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] ROW_LAST  = COORD_W'(V_ACTIVE - 2);
    localparam logic [COORD_W-1:0] LINES_ALL = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] LINES_PRM = COORD_W'(2);

    logic               vs_reg, vs_prev_reg;
    logic               de_reg, de_prev_reg;
    logic [PIX_W-1:0]   data_reg;
    state_t             state_reg, state_next;
    logic [COORD_W-1:0] col_in_reg, line_in_reg;
    logic [DRAIN_W-1:0] drain_cnt_reg;
    logic               err_reg;
    logic               rd_hs_reg;
    logic [COORD_W-1:0] win_row_reg, win_col_reg;

    logic               vs_rise, de_fall, in_frame, line_end;
    logic [COORD_W-1:0] line_in_inc;
    logic               wr_en, rd_en, frame_done;
    logic               dl_q, dl_pre, win_valid, win_end;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_reg      <= 1'b0;
            vs_prev_reg <= 1'b0;
            de_reg      <= 1'b0;
            de_prev_reg <= 1'b0;
            data_reg    <= '0;
        end else begin
            vs_reg      <= bus.in_vs;
            vs_prev_reg <= vs_reg;
            de_reg      <= bus.in_de;
            de_prev_reg <= de_reg;
            data_reg    <= bus.in_data;
        end
    end

    // A vs rise always wins: it restarts the frame even on a line's final edge.
    assign vs_rise     = vs_reg & ~vs_prev_reg;
    assign de_fall     = de_prev_reg & ~de_reg;
    assign in_frame    = (state_reg == ST_PRIME) || (state_reg == ST_RUN);
    assign line_end    = de_fall & in_frame & ~vs_rise;
    assign line_in_inc = line_in_reg + 1'b1;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (vs_rise) begin
            state_next = ST_PRIME;
        end else begin
            case (state_reg)
                ST_PRIME: if (line_end && line_in_inc == LINES_PRM) state_next = ST_RUN;
                ST_RUN:   if (line_end && line_in_inc == LINES_ALL) state_next = ST_DRAIN;
                ST_DRAIN: if (drain_cnt_reg == '0) state_next = ST_IDLE;
                default:  state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        frame_done = 1'b0;
        case (state_reg)
            ST_PRIME: wr_en = de_reg;
            ST_RUN: begin
                wr_en = de_reg;
                rd_en = de_reg;
            end
            ST_DRAIN: frame_done = (drain_cnt_reg == '0) && !vs_rise;
            default: ;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            col_in_reg  <= '0;
            line_in_reg <= '0;
            err_reg     <= 1'b0;
            rd_hs_reg   <= 1'b0;
        end else begin
            rd_hs_reg <= line_end && (state_reg == ST_RUN);
            if (vs_rise) begin
                col_in_reg  <= '0;
                line_in_reg <= '0;
                err_reg     <= 1'b0;
            end else if (in_frame) begin
                if (de_reg && col_in_reg != '1) begin
                    col_in_reg <= col_in_reg + 1'b1;
                end
                if (de_fall) begin
                    col_in_reg  <= '0;
                    line_in_reg <= line_in_inc;
                    if (col_in_reg != COL_LEN) begin
                        err_reg <= 1'b1;
                    end
                end
            end
        end
    end

    // Preloaded outside DRAIN so the count starts the moment DRAIN is entered.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            drain_cnt_reg <= '0;
        end else if (state_reg != ST_DRAIN) begin
            drain_cnt_reg <= DRAIN_LOAD;
        end else if (drain_cnt_reg != '0) begin
            drain_cnt_reg <= drain_cnt_reg - 1'b1;
        end
    end

    conv_delay_line #(
        .DEPTH (RD_LAT)
    ) u_valid_dly (
        .pclk  (pclk),
        .rst   (rst),
        .clr   (vs_rise),
        .d     (rd_en),
        .q     (dl_q),
        .q_pre (dl_pre)
    );

    assign win_valid = dl_q & ~vs_rise;
    assign win_end   = win_valid & ~dl_pre;

    // A window line ends when no further read is one stage behind the output.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            win_row_reg <= '0;
            win_col_reg <= '0;
        end else if (vs_rise) begin
            win_row_reg <= COORD_W'(1);
            win_col_reg <= '0;
        end else if (win_valid) begin
            if (win_end) begin
                win_col_reg <= '0;
                win_row_reg <= win_row_reg + 1'b1;
            end else begin
                win_col_reg <= win_col_reg + 1'b1;
            end
        end
    end

    assign bus.lb_wr_en   = wr_en;
    assign bus.lb_wr_data = wr_en ? data_reg : '0;
    assign bus.lb_rd_en   = rd_en;
    assign bus.lb_rd_hs   = rd_hs_reg;
    assign bus.win_valid  = win_valid;
    assign bus.win_row    = win_row_reg;
    assign bus.win_col    = win_col_reg;
    assign bus.win_border = win_valid && ((win_col_reg == '0) || (win_col_reg == COL_LAST) ||
                                          (win_row_reg == COORD_W'(1)) || (win_row_reg == ROW_LAST));
    assign bus.frame_done = frame_done;
    assign bus.err_line   = err_reg;

endmodule

// File: tb/tb_conv_linebuf_ctrl.sv
// Randomised bench for conv_linebuf_ctrl with a frame-level reference model
// (expected windows, written pixels and per-frame strobe counts).
module tb_conv_linebuf_ctrl;

    localparam int H  = 8;
    localparam int V  = 5;
    localparam int RL = 3;

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    conv_linebuf_ctrl_if bus ();

    conv_linebuf_ctrl #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .RD_LAT   (RL)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int wrq[$];
    int winq[$];
    bit sb_en = 1'b0;
    int wr_total = 0, rd_total = 0, win_total = 0, fd_total = 0;
    int fr_wr = 0, fr_rd = 0, fr_hs = 0, fr_fd = 0;
    int first_rd_cyc = -1, last_rd_cyc = 0;
    int line_len[8];

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int win_word(input int r, input int c, input int b);
        return (r << 11) | (c << 1) | b;
    endfunction

    function automatic int strobes();
        return {25'd0, bus.lb_wr_en, bus.lb_rd_en, bus.lb_rd_hs, bus.win_valid,
                bus.win_border, bus.frame_done, bus.err_line};
    endfunction

    // Observer: samples on the falling edge, scores writes and windows.
    always @(negedge pclk) begin
        if (!rst) begin
            if (bus.lb_wr_en) begin
                wr_total++; fr_wr++;
                if (sb_en) begin
                    if (wrq.size() == 0) chk("wr_extra", 1, 0);
                    else chk("wr_data", int'(bus.lb_wr_data), wrq.pop_front());
                end
            end
            if (bus.lb_rd_en) begin
                rd_total++; fr_rd++;
                last_rd_cyc = cyc;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (bus.lb_rd_hs) begin
                fr_hs++;
                chk("hs_vs_rd", int'(bus.lb_rd_en), 0);
            end
            if (bus.win_valid) begin
                win_total++;
                if (sb_en) begin
                    if (winq.size() == 0) chk("win_extra", 1, 0);
                    else chk("win", win_word(int'(bus.win_row), int'(bus.win_col), int'(bus.win_border)),
                             winq.pop_front());
                end
            end
            if (bus.frame_done) begin
                fd_total++; fr_fd++;
                chk("fd_lat", cyc - last_rd_cyc, RL + 1);
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic vs_pulse();
        bus.in_vs = 1'b1; tick(); tick();
        bus.in_vs = 1'b0; tick(); tick();
    endtask

    task automatic send_line(input int len, input bit push);
        int px;
        for (int c = 0; c < len; c++) begin
            px = int'($urandom_range(0, 65535));
            bus.in_de   = 1'b1;
            bus.in_data = px[15:0];
            if (push) wrq.push_back(px);
            tick();
        end
        bus.in_de = 1'b0;
    endtask

    task automatic frame_body(input int nlines);
        int exp_wr, exp_rd, err_final, err_sf, l3_cyc, nv, bdr;
        exp_wr = 0; exp_rd = 0; err_final = 0; err_sf = 0; l3_cyc = 0;
        fr_wr = 0; fr_rd = 0; fr_hs = 0; fr_fd = 0; first_rd_cyc = -1;
        nv = (nlines < V) ? nlines : V;
        for (int k = 1; k <= nv; k++) begin
            exp_wr += line_len[k-1];
            if (line_len[k-1] != H) err_final = 1;
            if (k >= 3) begin
                exp_rd += line_len[k-1];
                for (int c = 0; c < line_len[k-1]; c++) begin
                    bdr = (c == 0 || c == H - 1 || k - 2 == 1 || k - 2 == V - 2) ? 1 : 0;
                    winq.push_back(win_word(k - 2, c, bdr));
                end
            end
        end
        for (int k = 1; k <= nlines; k++) begin
            if (k == 3) begin
                chk("prime_wr", fr_wr, line_len[0] + line_len[1]);
                chk("prime_rd", fr_rd, 0);
                l3_cyc = cyc;
            end
            send_line(line_len[k-1], k <= V);
            repeat ($urandom_range(3, 6)) tick();
            if (k <= V) begin
                if (line_len[k-1] != H) err_sf = 1;
                chk("err_line", int'(bus.err_line), err_sf);
            end
            if (k == 3) chk("first_rd", first_rd_cyc - l3_cyc, 1);
        end
        for (int i = 0; i < 40 && fr_fd == 0; i++) tick();
        repeat (10) tick();
        chk("fd_count", fr_fd, 1);
        chk("err_end", int'(bus.err_line), err_final);
        chk("win_left", winq.size(), 0);
        chk("wr_left", wrq.size(), 0);
        chk("wr_count", fr_wr, exp_wr);
        chk("rd_count", fr_rd, exp_rd);
        chk("hs_count", fr_hs, V - 2);
    endtask

    task automatic send_frame(input int nlines);
        vs_pulse();
        chk("err_clr", int'(bus.err_line), 0);
        frame_body(nlines);
    endtask

    task automatic nominal_lens();
        for (int i = 0; i < 8; i++) line_len[i] = H;
    endtask

    int snap_win, snap_fd, snap_wr, snap_rd;

    initial begin
        bus.in_vs = 1'b0; bus.in_de = 1'b0; bus.in_data = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_strobes", strobes(), 0);
        chk("rst_coord", {12'd0, bus.win_row, bus.win_col}, 0);
        rst = 1'b0;
        send_line(H, 1'b0);
        repeat (6) tick();
        chk("idle_quiet", wr_total + rd_total + win_total + fd_total, 0);

        sb_en = 1'b1;
        nominal_lens();
        send_frame(5);
        line_len[1] = H - 1;
        send_frame(5);
        nominal_lens();
        send_frame(5);

        // abort: vs rises on the same cycle line 4 ends early
        vs_pulse();
        sb_en = 1'b0;
        snap_fd = fd_total;
        for (int k = 0; k < 3; k++) begin
            send_line(H, 1'b0);
            repeat (4) tick();
        end
        for (int c = 0; c < 4; c++) begin
            bus.in_de = 1'b1; bus.in_data = 16'(c); tick();
        end
        bus.in_de = 1'b0; bus.in_vs = 1'b1;
        tick();
        snap_win = win_total;
        tick();
        bus.in_vs = 1'b0;
        repeat (12) tick();
        chk("abort_squash", win_total, snap_win);
        chk("abort_no_fd", fd_total, snap_fd);
        chk("abort_err", int'(bus.err_line), 0);
        wrq.delete(); winq.delete();
        sb_en = 1'b1;
        frame_body(5);

        // asynchronous reset in the middle of line 3
        vs_pulse();
        sb_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            send_line(H, 1'b0);
            repeat (4) tick();
        end
        for (int c = 0; c < 4; c++) begin
            bus.in_de = 1'b1; bus.in_data = 16'($urandom); tick();
        end
        chk("run_rd_before_rst", int'(bus.lb_rd_en), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_strobes", strobes(), 0);
        chk("rst_mid_coord", {12'd0, bus.win_row, bus.win_col}, 0);
        chk("rst_mid_wdata", int'(bus.lb_wr_data), 0);
        tick(); tick();
        rst = 1'b0;
        snap_wr = wr_total; snap_rd = rd_total; snap_win = win_total; snap_fd = fd_total;
        tick(); tick();
        bus.in_de = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            send_line(H, 1'b0);
            repeat (4) tick();
        end
        chk("rst_quiet_wr", wr_total, snap_wr);
        chk("rst_quiet_rd", rd_total, snap_rd);
        chk("rst_quiet_win", win_total + fd_total, snap_win + snap_fd);
        wrq.delete(); winq.delete();
        sb_en = 1'b1;
        send_frame(5);

        send_frame(6);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++)
                line_len[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 10)) : H;
            send_frame(int'($urandom_range(5, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_linebuf_ctrl.md
# conv_linebuf_ctrl

Sequencing controller for the 3-row convolution line buffer on the `pclk` camera pixel path. It converts the incoming `vs`/`de` pixel timing into the write, read and row-toggle strobes the line buffer needs. It also handles the two-line priming phase and flags short or long lines. Downstream it provides a window-valid strobe aligned to the buffer's output, with centre-pixel row/column coordinates and a border flag for the 3x3 kernel stage.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `RD_LAT`, 3: cycles from `lb_rd_en` to the aligned 3-row column at the line-buffer outputs.
- `pclk` input 1: pixel clock, the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `in_vs` input 1: frame sync, active-high; its rising edge marks frame start.
- `in_de` input 1: active-pixel strobe, one pixel per cycle while high.
- `in_data` input 16: RGB565 pixel.
- `lb_wr_en` output 1: line-buffer write enable.
- `lb_wr_data` output 16: line-buffer write data.
- `lb_rd_en` output 1: line-buffer read enable.
- `lb_rd_hs` output 1: one-cycle row-toggle pulse per consumed line.
- `win_valid` output 1: the 3x3 column at the buffer outputs is valid this cycle.
- `win_row` output 10: centre row, valid range 1..V_ACTIVE-2.
- `win_col` output 10: centre column, valid range 0..H_ACTIVE-1.
- `win_border` output 1: centre sits on col 0, col H_ACTIVE-1, row 1 or row V_ACTIVE-2.
- `frame_done` output 1: one-cycle pulse after the last window of a frame.
- `err_line` output 1: sticky flag for a line-length error, cleared at the next frame start.

## Operation
- **Registered inputs.** `in_vs`, `in_de` and `in_data` are each registered once. Edge detection runs on the registered copies.
- **Counters.** `col_in` counts `de` cycles per line and saturates at 1023. `line_in` counts `de` falling edges within the frame.
- **FSM state IDLE.** All strobes are low. A `vs` rise moves to PRIME and clears `col_in`, `line_in`, `win_row`, `win_col` and `err_line`.
- **FSM state PRIME.**
  - `lb_wr_en` = registered `de`; `lb_wr_data` = registered data.
  - `lb_rd_en` stays low.
  - Move to RUN when the `de` falling edge takes `line_in` to 2.
- **FSM state RUN.**
  - `lb_wr_en` = `lb_rd_en` = registered `de`.
  - `lb_rd_hs` pulses on the cycle after each `de` falling edge.
  - When the falling edge takes `line_in` to V_ACTIVE, move to DRAIN.
- **FSM state DRAIN.**
  - Wait RD_LAT+1 cycles with a down-counter, then pulse `frame_done` and return to IDLE.
  - Any `de` arriving in DRAIN or IDLE is ignored: no write, no read.
- **Line-length check.** At a `de` falling edge, if `col_in` != H_ACTIVE, set `err_line`. The line is still written and read as delivered, and `line_in` still advances.
- **`vs` rise in PRIME, RUN or DRAIN.** Abort the frame: no `frame_done`, in-flight `win_valid` is squashed, counters are cleared, and the FSM re-enters PRIME.
- **Window coordinates.**
  - `win_col` increments on each `win_valid` and resets to 0 on the cycle after the last window of a line.
  - `win_row` starts at 1 and increments when a line of windows completes.
  - `win_border` is combinational from the registered `win_row` and `win_col`.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- Input to line-buffer strobes: 1 cycle of latency (the input register).
- `win_valid` = `lb_rd_en` delayed exactly RD_LAT cycles through a shift register. The abort case clears this shift register.
- `win_row` and `win_col` are registered and coincide with `win_valid`.
- `frame_done` asserts RD_LAT+1 cycles after the last `lb_rd_en` of the frame.
- `lb_rd_hs` never coincides with `lb_rd_en`, because it follows the `de` falling edge.
- A simultaneous `vs` rise and `de` falling edge resolves as abort. That line is not counted and `err_line` is not updated.

## Structure
- Shared package `conv_pkg`: FSM state encoding (IDLE, PRIME, RUN, DRAIN), the RGB565 pixel width constant, and the coordinate width (10).
- One sub-module, `conv_delay_line`: a parameterised 1-bit shift register of depth RD_LAT with synchronous clear, used for `win_valid` alignment.
- The counters and FSM stay in the top module.

## Test plan
All scenarios use H_ACTIVE=8, V_ACTIVE=5, RD_LAT=3.
- **Nominal frame.** Five 8-pixel lines with a 4-cycle blank between lines → 24 `win_valid` pulses, `win_row` 1..3 and `win_col` 0..7. Border is set on cols 0 and 7 and rows 1 and 3. `frame_done` pulses once, 4 cycles after the last read. `err_line` stays 0.
- **Priming.** Count strobes over the first two lines → 16 `lb_wr_en` cycles and 0 `lb_rd_en` cycles. The first `lb_rd_en` is 1 cycle after line 3's first `de`.
- **Line-length error.** Line 2 has 7 pixels → `err_line` goes high at its end and stays high through `frame_done`. It clears at the next `vs` rise.
- **Mid-frame abort.** `vs` rises during line 4 → in-flight `win_valid` is squashed, no `frame_done`, FSM returns to PRIME. The next full frame yields 24 windows.
- **Reset mid-frame.** Assert `rst` during line 3, RUN state → all outputs are 0 on the same cycle. After release, no strobes appear until a `vs` rise.
- **Extra lines.** Six lines in one frame → the sixth line produces no `lb_wr_en` or `lb_rd_en`, and `frame_done` pulses once.
